// File: rtl/mano_timing_ctrl.sv
// mano_timing_ctrl
//   Timing and control unit for the Mano basic computer. It holds the 3-bit
//   sequence counter (SC), the run flip-flop, the decoded opcode (D0..D7) and
//   the latched indirect bit. From these it drives all register and memory
//   control strobes combinationally.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   start                          pulse that sets the run flip-flop when idle
//   ir[15:0]                       current instruction register contents
//   ac_sign, ac_zero, e_zero,      status: AC[15], AC==0, E==0, DR==0
//   dr_zero
//   t[7:0], d[7:0]                 one-hot timing (T0..T7) and opcode (D0..D7)
//   i_flag, running                latched indirect bit, run flip-flop
//   ar_ld .. mem_wr                register load/inc/clr and memory strobes
//   bus_sel[2:0]                   1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM, 0 none
//   alu_op[2:0]                    0 AND, 1 ADD, 2 DR, 3 CMA, 4 CIR, 5 CIL
module mano_timing_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        ac_sign,
  input  logic        ac_zero,
  input  logic        e_zero,
  input  logic        dr_zero,
  output logic [7:0]  t,
  output logic [7:0]  d,
  output logic        i_flag,
  output logic        running,
  output logic        ar_ld,
  output logic        ar_inc,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        dr_ld,
  output logic        dr_inc,
  output logic        ir_ld,
  output logic        ac_ld,
  output logic        ac_clr,
  output logic        ac_inc,
  output logic        e_clr,
  output logic        e_cmp,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  bus_sel,
  output logic [2:0]  alu_op
);

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_DR   = 3'd2;
  localparam logic [2:0] ALU_CMA  = 3'd3;
  localparam logic [2:0] ALU_CIR  = 3'd4;
  localparam logic [2:0] ALU_CIL  = 3'd5;

  logic [2:0] sc;
  logic       sc_clr;
  logic       halt;
  logic       skip;

  assign t = running ? (8'd1 << sc) : 8'h00;

  // Skip conditions are ORed so several skip bits still give one PC increment.
  assign skip = (ir[4] & ~ac_sign) | (ir[3] & ac_sign) |
                (ir[2] & ac_zero)  | (ir[1] & e_zero);

  // Control decode: combinational from SC, D, I, IR and status
  always_comb begin
    ar_ld   = 1'b0;
    ar_inc  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    dr_ld   = 1'b0;
    dr_inc  = 1'b0;
    ir_ld   = 1'b0;
    ac_ld   = 1'b0;
    ac_clr  = 1'b0;
    ac_inc  = 1'b0;
    e_clr   = 1'b0;
    e_cmp   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    bus_sel = BUS_NONE;
    alu_op  = ALU_AND;
    sc_clr  = 1'b0;
    halt    = 1'b0;
    if (running) begin
      case (sc)
        3'd0: begin
          bus_sel = BUS_PC;
          ar_ld   = 1'b1;
        end
        3'd1: begin
          mem_rd  = 1'b1;
          bus_sel = BUS_MEM;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        3'd2: begin
          bus_sel = BUS_IR;
          ar_ld   = 1'b1;
        end
        3'd3: begin
          if (d[7]) begin
            // I/O (I=1) is a NOP; register reference executes here.
            sc_clr = 1'b1;
            if (!i_flag) begin
              // Only the highest set AC-modifying bit acts.
              if (ir[11]) begin
                ac_clr = 1'b1;
              end else if (ir[9]) begin
                ac_ld  = 1'b1;
                alu_op = ALU_CMA;
              end else if (ir[7]) begin
                ac_ld  = 1'b1;
                alu_op = ALU_CIR;
              end else if (ir[6]) begin
                ac_ld  = 1'b1;
                alu_op = ALU_CIL;
              end else if (ir[5]) begin
                ac_inc = 1'b1;
              end
              e_clr  = ir[10];
              e_cmp  = ir[8];
              pc_inc = skip;
              halt   = ir[0];
            end
          end else if (i_flag) begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            ar_ld   = 1'b1;
          end
        end
        3'd4: begin
          if (d[0] | d[1] | d[2] | d[6]) begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            dr_ld   = 1'b1;
          end else if (d[3]) begin
            bus_sel = BUS_AC;
            mem_wr  = 1'b1;
            sc_clr  = 1'b1;
          end else if (d[4]) begin
            bus_sel = BUS_AR;
            pc_ld   = 1'b1;
            sc_clr  = 1'b1;
          end else if (d[5]) begin
            bus_sel = BUS_PC;
            mem_wr  = 1'b1;
            ar_inc  = 1'b1;
          end
        end
        3'd5: begin
          if (d[0] | d[1] | d[2]) begin
            ac_ld  = 1'b1;
            alu_op = d[1] ? ALU_ADD : (d[2] ? ALU_DR : ALU_AND);
            sc_clr = 1'b1;
          end else if (d[5]) begin
            bus_sel = BUS_AR;
            pc_ld   = 1'b1;
            sc_clr  = 1'b1;
          end else if (d[6]) begin
            dr_inc = 1'b1;
          end
        end
        3'd6: begin
          if (d[6]) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            pc_inc  = dr_zero;
            sc_clr  = 1'b1;
          end
        end
        default: begin
          // T7 is never part of an instruction: recover to T0 silently.
          sc_clr = 1'b1;
        end
      endcase
    end
  end

  // State: SC, run flip-flop, opcode decode and indirect bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc      <= 3'd0;
      running <= 1'b0;
      i_flag  <= 1'b0;
      d       <= 8'h00;
    end else if (!running) begin
      if (start) begin
        running <= 1'b1;
        sc      <= 3'd0;
      end
    end else begin
      if (halt) begin
        running <= 1'b0;
      end
      sc <= sc_clr ? 3'd0 : (sc + 3'd1);
      if (sc == 3'd2) begin
        d      <= 8'd1 << ir[14:12];
        i_flag <= ir[15];
      end
    end
  end

endmodule

// File: doc/mano_timing_ctrl.md
MANO_TIMING_CTRL -- requirements
Module: mano_timing_ctrl

Interface
REQ-001 The block SHALL have ports `clk` (in, 1): rising-edge clock for all state.
REQ-002 The block SHALL have port `rst` (in, 1): reset, asynchronous and active-high.
REQ-003 The block SHALL have port `start` (in, 1): single-cycle pulse that sets the run flip-flop.
REQ-004 The block SHALL have port `ir` (in, 16): current IR contents.
REQ-005 The block SHALL have status inputs `ac_sign`, `ac_zero`, `e_zero`, `dr_zero` (in, 1 each): AC[15], AC==0, E==0, DR==0.
REQ-006 The block SHALL have outputs `t` (8) and `d` (8): one-hot timing signals T0..T7 and decoded opcode D0..D7.
REQ-007 The block SHALL have outputs `i_flag` and `running` (1 each): latched indirect bit and run flip-flop.
REQ-008 The block SHALL have load/increment/clear outputs (1 each): `ar_ld`, `ar_inc`, `pc_ld`, `pc_inc`, `dr_ld`, `dr_inc`, `ir_ld`, `ac_ld`, `ac_clr`, `ac_inc`, `e_clr`, `e_cmp`, `mem_rd`, `mem_wr`.
REQ-009 The block SHALL have outputs `bus_sel` (3) and `alu_op` (3).
 - `bus_sel` encoding: 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM, 0 none.
 - `alu_op` encoding: 0 AND, 1 ADD, 2 DR-pass, 3 CMA, 4 CIR, 5 CIL.

Function
REQ-010 The 3-bit sequence counter SC SHALL increment each clock while `running`=1, and SHALL clear on every instruction-ending step.
REQ-011 `t` SHALL equal one-hot(SC) while `running`=1, and SHALL be 8'h00 while `running`=0.
REQ-012 A `start` pulse while idle SHALL set `running` at the next edge, with SC=0; a `start` pulse while running SHALL be ignored.
REQ-013 At T0 the block SHALL assert `bus_sel`=2 and `ar_ld`.
REQ-014 At T1 the block SHALL assert `mem_rd`, `bus_sel`=7, `ir_ld` and `pc_inc`.
REQ-015 At T2 the block SHALL assert `bus_sel`=5 and `ar_ld`, and at the T2 edge SHALL register `d`<=one-hot(ir[14:12]) and `i_flag`<=ir[15].
REQ-016 At T3 with D7=0:
 - if `i_flag`=1, the block SHALL assert `mem_rd`, `bus_sel`=7 and `ar_ld`;
 - otherwise no control output SHALL be asserted.
REQ-017 Memory-reference steps SHALL be:
 - D0/D1/D2 T4: `mem_rd`, `bus_sel`=7, `dr_ld`.
 - D0/D1/D2 T5: `ac_ld` with `alu_op` 0/1/2 respectively; SC clears.
 - D3 T4: `bus_sel`=4, `mem_wr`; SC clears.
 - D4 T4: `bus_sel`=1, `pc_ld`; SC clears.
 - D5 T4: `bus_sel`=2, `mem_wr`, `ar_inc`.
 - D5 T5: `bus_sel`=1, `pc_ld`; SC clears.
 - D6 T4: DR load as for D0.
 - D6 T5: `dr_inc`.
 - D6 T6: `bus_sel`=3, `mem_wr`, `pc_inc` if `dr_zero`; SC clears.
REQ-018 D7 with `i_flag`=0 (register reference) SHALL execute at T3, SC SHALL clear, and the decode SHALL be:
 - ir[11] `ac_clr`; ir[10] `e_clr`; ir[9] `ac_ld` with op 3; ir[8] `e_cmp`;
 - ir[7] `ac_ld` with op 4; ir[6] `ac_ld` with op 5; ir[5] `ac_inc`;
 - ir[4] skip if !`ac_sign`; ir[3] skip if `ac_sign`; ir[2] skip if `ac_zero`; ir[1] skip if `e_zero`;
 - ir[0] HLT.
 - A skip SHALL assert `pc_inc`.
REQ-019 When several ir[11:0] bits are set:
 - skip conditions SHALL be ORed into a single `pc_inc`;
 - among AC-modifying bits (11, 9, 7, 6, 5), only the highest set bit SHALL act;
 - `e_clr`/`e_cmp` SHALL act independently.
REQ-020 D7 with `i_flag`=1 (I/O) SHALL be a NOP at T3, and SC SHALL clear.
REQ-021 HLT SHALL clear `running` and SC at the T3 edge.
REQ-022 If SC reaches 7, SC SHALL clear at the next edge and no control output SHALL be asserted.
REQ-023 All control outputs SHALL be combinational from SC, `d`, `i_flag`, `ir` and the status inputs.
REQ-024 All control outputs SHALL be 0 whenever `running`=0.

Reset
REQ-025 While `rst`=1, the block SHALL asynchronously force SC=0, `running`=0, `i_flag`=0, `d`=8'h00 and `t`=8'h00, and every control output, `bus_sel` and `alu_op` SHALL read 0.
REQ-026 Asserting `rst` mid-instruction SHALL abort the instruction, and no control output SHALL be asserted after the next rising edge of `clk` once `rst` is released.
REQ-027 After reset release the block SHALL remain idle until `start`.

Verification
REQ-028 Bench SHALL cover: `ir`=16'h2123 (LDA direct), `start` -> T0..T5 observed, `dr_ld` at T4, `ac_ld` with op 2 at T5, SC=0 after 6 clocks.
REQ-029 Bench SHALL cover: `ir`=16'hC200 (BUN indirect) -> `mem_rd`+`ar_ld` at T3, `pc_ld` with `bus_sel`=1 at T4, `i_flag`=1.
REQ-030 Bench SHALL cover: `ir`=16'h6050 (ISZ) with `dr_zero`=1 at T6 -> `mem_wr` and `pc_inc` at T6; repeated with `dr_zero`=0 -> no `pc_inc`.
REQ-031 Bench SHALL cover: `ir`=16'h7A00 (CLA+CMA) -> `ac_clr` only, no `alu_op` 3 load; `ir`=16'h7014 (SPA+SZA) with `ac_sign`=0 -> a single `pc_inc`.
REQ-032 Bench SHALL cover: `ir`=16'h7001 (HLT) -> `running` falls after T3, `t`=0; a later `start` restarts at T0.
REQ-033 Bench SHALL cover: `rst` asserted at T4 of ADD -> all outputs 0 immediately; `start` during run is ignored.
